eq_sweep_checker: RTL and testbench

//  Self-checking stimulus/response engine for W-bit equality comparators.
//  - Drives every (x,y) pair in the 2^(2W) space.
//  - Samples the comparator result z and scores it against expected (x==y).
//  - Reports pass/fail, error count and first failing vector.
//  - Sits opposite a comparator DUT: drives its x/y inputs, consumes its z output.

---
 rtl/eq_sweep_checker_pkg.sv | 14 +
 rtl/eq_sweep_checker.sv | 118 +++++++++++
 tb/tb_eq_sweep_checker.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/eq_sweep_checker_pkg.sv
// Shared constants for the equality-comparator sweep checker:
// FSM state encodings and default parameter values.
package eq_sweep_checker_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_W      = 2;
    localparam int DEF_SETTLE = 1;
    localparam int DEF_ERRW   = 8;

endpackage

// File: rtl/eq_sweep_checker.sv
// Sweeps every (x,y) operand pair into a W-bit equality comparator and scores
// its z output against x==y, reporting pass/fail, error count and first failure.
//
// state | meaning
// IDLE  | after reset, waiting for start
// WAIT  | operands applied, letting the comparator settle; z captured on exit
// CHECK | score captured z against x==y, then advance or finish
// DONE  | sweep complete, results held until next start
module eq_sweep_checker
    import eq_sweep_checker_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int SETTLE = DEF_SETTLE,
    parameter int ERRW   = DEF_ERRW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [W-1:0]    x,
    output logic [W-1:0]    y,
    input  logic            z,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic            fail_valid,
    output logic [W-1:0]    first_fail_x,
    output logic [W-1:0]    first_fail_y
);

    localparam int IW = 2 * W;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          z_s;
    logic          any_mis;
    logic          exp_eq;
    logic          mis;

    // idx is the only operand register; x is the slow operand, y the fast one
    assign x      = idx[IW-1:W];
    assign y      = idx[W-1:0];
    assign exp_eq = (x == y);
    // case inequality so an unknown z is scored as a mismatch
    assign mis    = (z_s !== exp_eq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            cnt          <= '0;
            z_s          <= 1'b0;
            any_mis      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            first_fail_x <= '0;
            first_fail_y <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx          <= '0;
                        cnt          <= CNT_INIT;
                        any_mis      <= 1'b0;
                        err_count    <= '0;
                        fail_valid   <= 1'b0;
                        first_fail_x <= '0;
                        first_fail_y <= '0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        z_s   <= z;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (mis) begin
                        any_mis <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_valid   <= 1'b1;
                            first_fail_x <= x;
                            first_fail_y <= y;
                        end
                    end
                    if (&idx) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // sticky flag keeps pass honest once err_count saturates
                        pass  <= !(any_mis || mis);
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        cnt   <= CNT_INIT;
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_sweep_checker.sv
// Bench for eq_sweep_checker: main instance scored through an expected-result
// queue, plus side instances for saturation and pipelined-comparator cases.
module tb_eq_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start_aux;
    logic [1:0] mode;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // main instance: mode 0 correct comparator, 1 z tied low, 2 inverted
    logic [1:0] x0, y0, ffx0, ffy0;
    logic       z0, busy0, done0, pass0, fv0;
    logic [7:0] err0;
    assign z0 = (mode == 2'd0) ? (x0 == y0) : (mode == 2'd1) ? 1'b0 : (x0 != y0);

    eq_sweep_checker #(.W(2), .SETTLE(1), .ERRW(8)) u0 (
        .clk(clk), .rst(rst), .start(start0), .x(x0), .y(y0), .z(z0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .first_fail_x(ffx0), .first_fail_y(ffy0)
    );

    // narrow error counter, inverted comparator
    logic [1:0] x1, y1, ffx1, ffy1, err1;
    logic       z1, busy1, done1, pass1, fv1;
    assign z1 = (x1 != y1);

    eq_sweep_checker #(.W(2), .SETTLE(1), .ERRW(2)) u1 (
        .clk(clk), .rst(rst), .start(start_aux), .x(x1), .y(y1), .z(z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail_x(ffx1), .first_fail_y(ffy1)
    );

    // one-register comparator with adequate settle time
    logic [1:0] x2, y2, ffx2, ffy2;
    logic       z2 = 1'b0, busy2, done2, pass2, fv2;
    logic [7:0] err2;
    always @(posedge clk) z2 <= (x2 == y2);

    eq_sweep_checker #(.W(2), .SETTLE(2), .ERRW(8)) u2 (
        .clk(clk), .rst(rst), .start(start_aux), .x(x2), .y(y2), .z(z2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .first_fail_x(ffx2), .first_fail_y(ffy2)
    );

    // same registered comparator but settle too short
    logic [1:0] x3, y3, ffx3, ffy3;
    logic       z3 = 1'b0, busy3, done3, pass3, fv3;
    logic [7:0] err3;
    always @(posedge clk) z3 <= (x3 == y3);

    eq_sweep_checker #(.W(2), .SETTLE(1), .ERRW(8)) u3 (
        .clk(clk), .rst(rst), .start(start_aux), .x(x3), .y(y3), .z(z3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail_x(ffx3), .first_fail_y(ffy3)
    );

    typedef struct {
        int         tag;
        int         cyc;
        logic       pass;
        int         err;
        logic       fv;
        logic [1:0] ffx;
        logic [1:0] ffy;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    logic done0_q = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // monitor: scores u0 each time done rises
    always @(negedge clk) begin
        if (done0 && !done0_q) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no completion at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                $display("scoring sweep tag %0d", e.tag);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", int'(busy0), 0);
                chk("pass", int'(pass0), int'(e.pass));
                chk("err_count", int'(err0), e.err);
                chk("fail_valid", int'(fv0), int'(e.fv));
                chk("first_fail_x", int'(ffx0), int'(e.ffx));
                chk("first_fail_y", int'(ffy0), int'(e.ffy));
                chk("x_hold_last", int'(x0), 3);
                chk("y_hold_last", int'(y0), 3);
            end
        end
        done0_q = done0;
    end

    task automatic issue(input int tagv, input logic [1:0] m, input bit push,
                         input logic p, input int err, input logic fv,
                         input logic [1:0] fx, input logic [1:0] fy);
        @(negedge clk);
        mode   = m;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("start_busy", int'(busy0), 1);
        chk("start_done_drop", int'(done0), 0);
        chk("start_err_clear", int'(err0), 0);
        chk("start_fv_clear", int'(fv0), 0);
        chk("start_xy_zero", int'({x0, y0}), 0);
        if (push) sbq.push_back('{tagv, cyc + 32, p, err, fv, fx, fy});
    endtask

    task automatic wait_done0(input int limit);
        int n = 0;
        while (!done0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=0 want done=1 within %0d cycles", limit);
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero();
        chk("rst_x", int'(x0), 0);
        chk("rst_y", int'(y0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_fv", int'(fv0), 0);
        chk("rst_ffx", int'(ffx0), 0);
        chk("rst_ffy", int'(ffy0), 0);
    endtask

    int s;
    int n;

    initial begin
        rst = 1'b1; start0 = 1'b0; start_aux = 1'b0; mode = 2'd0;
        repeat (3) @(negedge clk);
        check_all_zero();
        rst = 1'b0;

        // correct comparator, with a stray start mid-sweep that must be ignored
        issue(1, 2'd0, 1'b1, 1'b1, 0, 1'b0, 2'd0, 2'd0);
        repeat (4) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("busy_mid_sweep", int'(busy0), 1);
        wait_done0(100);

        // z stuck low, then inverted comparator (each restart from DONE)
        issue(2, 2'd1, 1'b1, 1'b0, 4, 1'b1, 2'd0, 2'd0);
        wait_done0(100);
        issue(3, 2'd2, 1'b1, 1'b0, 16, 1'b1, 2'd0, 2'd0);
        wait_done0(100);
        issue(4, 2'd0, 1'b1, 1'b1, 0, 1'b0, 2'd0, 2'd0);
        wait_done0(100);

        // asynchronous reset mid-sweep, then a clean rerun
        issue(5, 2'd0, 1'b0, 1'b0, 0, 1'b0, 2'd0, 2'd0);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero();
        @(negedge clk);
        rst = 1'b0;
        issue(6, 2'd0, 1'b1, 1'b1, 0, 1'b0, 2'd0, 2'd0);
        wait_done0(100);

        // side instances: saturation and pipelined comparator
        @(negedge clk);
        start_aux = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start_aux = 1'b0;
        n = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("u2_done_cycles", cyc - s, 48);
        chk("u2_pass", int'(pass2), 1);
        chk("u2_err", int'(err2), 0);
        chk("u1_done", int'(done1), 1);
        chk("u1_err_sat", int'(err1), 3);
        chk("u1_pass", int'(pass1), 0);
        chk("u1_fv", int'(fv1), 1);
        chk("u3_done", int'(done3), 1);
        chk("u3_err_nonzero", int'(err3 != 8'd0), 1);
        chk("u3_pass", int'(pass3), 0);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
